// File: rtl/sbox_9_pkg.sv
// Shared constants and the KASUMI S9 substitution table for the sbox_9 leaf cell.
// The table is held as a constant array so it synthesises to ROM/logic without a file read.
package sbox_9_pkg;

    localparam int SBOX_WIDTH = 9;
    localparam SBOX9_INIT_FILE = "sbox9_table.hex";

    // Entry k is S(k); 32 rows of 16 entries, row r covers indices 16r..16r+15.
    localparam logic [8:0] SBOX9_TABLE [512] = '{
        167, 239, 161, 379, 391, 334,   9, 338,  38, 226,  48, 358, 452, 385,  90, 397,
        183, 253, 147, 331, 415, 340,  51, 362, 306, 500, 262,  82, 216, 159, 356, 177,
        175, 241, 489,  37, 206,  17,   0, 333,  44, 254, 378,  58, 143, 220,  81, 400,
         95,   3, 315, 245,  54, 235, 218, 405, 472, 264, 172, 494, 371, 290, 399,  76,
        165, 197, 395, 121, 257, 480, 423, 212, 240,  28, 462, 176, 406, 507, 288, 223,
        501, 407, 249, 265,  89, 186, 221, 428, 164,  74, 440, 196, 458, 421, 350, 163,
        232, 158, 134, 354,  13, 250, 491, 142, 191,  69, 193, 425, 152, 227, 366, 135,
        344, 300, 276, 242, 437, 320, 113, 278,  11, 243,  87, 317,  36,  93, 496,  27,
        487, 446, 482,  41,  68, 156, 457, 131, 326, 403, 339,  20,  39, 115, 442, 124,
        475, 384, 508,  53, 112, 170, 479, 151, 126, 169,  73, 268, 279, 321, 168, 364,
        363, 292,  46, 499, 393, 327, 324,  24, 456, 267, 157, 460, 488, 426, 309, 229,
        439, 506, 208, 271, 349, 401, 434, 236,  16, 209, 359,  52,  56, 120, 199, 277,
        465, 416, 252, 287, 246,   6,  83, 305, 420, 345, 153, 502,  65,  61, 244, 282,
        173, 222, 418,  67, 386, 368, 261, 101, 476, 291, 195, 430,  49,  79, 166, 330,
        280, 383, 373, 128, 382, 408, 155, 495, 367, 388, 274, 107, 459, 417,  62, 454,
        132, 225, 203, 316, 234,  14, 301,  91, 503, 286, 424, 211, 347, 307, 140, 374,
         35, 103, 125, 427,  19, 214, 453, 146, 498, 314, 444, 230, 256, 329, 198, 285,
         50, 116,  78, 410,  10, 205, 510, 171, 231,  45, 139, 467,  29,  86, 505,  32,
         72,  26, 342, 150, 313, 490, 431, 238, 411, 325, 149, 473,  40, 119, 174, 355,
        185, 233, 389,  71, 448, 273, 372,  55, 110, 178, 322,  12, 469, 392, 369, 190,
          1, 109, 375, 137, 181,  88,  75, 308, 260, 484,  98, 272, 370, 275, 412, 111,
        336, 318,   4, 504, 492, 259, 304,  77, 337, 435,  21, 357, 303, 332, 483,  18,
         47,  85,  25, 497, 474, 289, 100, 269, 296, 478, 270, 106,  31, 104, 433,  84,
        414, 486, 394,  96,  99, 154, 511, 148, 413, 361, 409, 255, 162, 215, 302, 201,
        266, 351, 343, 144, 441, 365, 108, 298, 251,  34, 182, 509, 138, 210, 335, 133,
        311, 352, 328, 141, 396, 346, 123, 319, 450, 281, 429, 228, 443, 481,  92, 404,
        485, 422, 248, 297,  23, 213, 130, 466,  22, 217, 283,  70, 294, 360, 419, 127,
        312, 377,   7, 468, 194,   2, 117, 295, 463, 258, 224, 447, 247, 187,  80, 398,
        284, 353, 105, 390, 299, 471, 470, 184,  57, 200, 348,  63, 204, 188,  33, 451,
         97,  30, 310, 219,  94, 160, 129, 493,  64, 179, 263, 102, 189, 207, 114, 402,
        438, 477, 387, 122, 192,  42, 381,   5, 145, 118, 180, 449, 293, 323, 136, 380,
         43,  66,  60, 455, 341, 445, 202, 432,   8, 237,  15, 376, 436, 464,  59, 461
    };

    function automatic logic [8:0] sbox9_ref(input logic [8:0] x);
        return SBOX9_TABLE[x];
    endfunction

endpackage

// File: rtl/sbox_9_lut.sv
// Purely combinational S9 lookup: index the constant table with the unsigned input word.
module sbox_9_lut
    import sbox_9_pkg::*;
(
    input  logic [SBOX_WIDTH-1:0] a,
    output logic [SBOX_WIDTH-1:0] z
);

    always_comb begin
        z = SBOX9_TABLE[a];
    end

endmodule

// File: rtl/sbox_9.sv
// Registered S9 substitution box: one cycle of latency with an aligned valid flag.
// z holds its last value when no input is accepted, so idle X on a never reaches it.
module sbox_9
    import sbox_9_pkg::*;
#(
    parameter int WIDTH = SBOX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic [WIDTH-1:0] z,
    output logic             z_valid
);

    logic [WIDTH-1:0] lutZ;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] z_d;
    logic             zValid_q;
    logic             zValid_d;

    sbox_9_lut u_lut (
        .a (a),
        .z (lutZ)
    );

    always_comb begin
        z_d      = z_q;
        zValid_d = 1'b0;
        if (a_valid) begin
            z_d      = lutZ;
            zValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q      <= '0;
            zValid_q <= 1'b0;
        end else begin
            z_q      <= z_d;
            zValid_q <= zValid_d;
        end
    end

    assign z       = z_q;
    assign z_valid = zValid_q;

endmodule

// File: tb/tb_sbox_9.sv
// Directed self-checking bench for sbox_9: reset, single lookups, full stream with
// bijectivity, hold with junk input, mid-stream reset and table boundaries.
module tb_sbox_9;
    import sbox_9_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [8:0] a;
    logic       a_valid;
    logic [8:0] z;
    logic       z_valid;

    int vectorCount = 0;
    int errorCount  = 0;

    bit seen [512];
    int dupCount;
    int missCount;

    sbox_9 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .a_valid (a_valid),
        .z       (z),
        .z_valid (z_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectorCount++;
        assert (obs === exp)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one input word just after the falling edge, then sample 1ns after the rising edge.
    task automatic applyStimulus(input logic [8:0] word, input logic valid);
        @(negedge clk);
        a       = word;
        a_valid = valid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] sbox_9 bench, table source name %s", SBOX9_INIT_FILE);
        rst_n   = 1'b0;
        a       = 9'h003;
        a_valid = 1'b1;
        #1;
        checkOutput("reset_z_async", z, 9'h000);
        checkOutput("reset_zv_async", {8'h0, z_valid}, 9'h000);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold_z", z, 9'h000);
            checkOutput("reset_hold_zv", {8'h0, z_valid}, 9'h000);
        end

        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 1'b0;

        applyStimulus(9'h000, 1'b1);
        checkOutput("single_0_z", z, 9'h0A7);
        checkOutput("single_0_zv", {8'h0, z_valid}, 9'h001);
        applyStimulus(9'h000, 1'b0);
        checkOutput("single_0_pulse", {8'h0, z_valid}, 9'h000);
        checkOutput("single_0_hold", z, 9'h0A7);

        applyStimulus(9'h001, 1'b1);
        checkOutput("single_1_z", z, 9'h0EF);
        checkOutput("single_1_zv", {8'h0, z_valid}, 9'h001);
        applyStimulus(9'h000, 1'b0);
        checkOutput("single_1_pulse", {8'h0, z_valid}, 9'h000);

        applyStimulus(9'h003, 1'b1);
        checkOutput("single_3_z", z, 9'h17B);
        checkOutput("single_3_zv", {8'h0, z_valid}, 9'h001);

        // Asynchronous clear between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_z", z, 9'h000);
        checkOutput("async_rst_zv", {8'h0, z_valid}, 9'h000);
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 1'b0;

        // Full stream with bijectivity collection.
        dupCount = 0;
        for (int k = 0; k < 512; k++) seen[k] = 1'b0;
        for (int k = 0; k < 512; k++) begin
            applyStimulus(9'(k), 1'b1);
            checkOutput("stream_z", z, sbox9_ref(9'(k)));
            checkOutput("stream_zv", {8'h0, z_valid}, 9'h001);
            if (seen[z]) dupCount++;
            seen[z] = 1'b1;
        end
        missCount = 0;
        for (int k = 0; k < 512; k++) if (!seen[k]) missCount++;
        checkOutput("bijective_dups", 9'(dupCount), 9'd0);
        checkOutput("bijective_missing", 9'(missCount), 9'd0);

        // Hold with random and unknown input words while idle.
        applyStimulus(9'h004, 1'b1);
        checkOutput("hold_first_z", z, 9'h187);
        checkOutput("hold_first_zv", {8'h0, z_valid}, 9'h001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i == 2) ? 9'bx : 9'($urandom_range(0, 511)), 1'b0);
            checkOutput("hold_z", z, 9'h187);
            checkOutput("hold_zv", {8'h0, z_valid}, 9'h000);
        end

        // Mid-stream reset.
        for (int k = 16; k < 25; k++) begin
            applyStimulus(9'(k), 1'b1);
            checkOutput("midstream_z", z, sbox9_ref(9'(k)));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midstream_rst_z", z, 9'h000);
        checkOutput("midstream_rst_zv", {8'h0, z_valid}, 9'h000);
        @(posedge clk);
        #1;
        checkOutput("midstream_rst_edge_z", z, 9'h000);
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        applyStimulus(9'h005, 1'b1);
        checkOutput("after_rst_z", z, 9'h14E);
        checkOutput("after_rst_zv", {8'h0, z_valid}, 9'h001);

        // Table boundaries.
        applyStimulus(9'h1FF, 1'b1);
        checkOutput("boundary_1ff", z, 9'h1CD);
        applyStimulus(9'h100, 1'b1);
        checkOutput("boundary_100", z, 9'h023);
        applyStimulus(9'h000, 1'b0);
        checkOutput("boundary_idle_zv", {8'h0, z_valid}, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sbox_9.md
Name: sbox_9

Overview:
- Registered 9-bit substitution box. Maps a 9-bit input word `a` to a 9-bit output word `z` through a fixed bijective lookup table.
- The table is the KASUMI S9 table (3GPP TS 35.202).
- Used as a leaf cell in the cipher datapath and exhaustively checked against a 512-entry golden input/output vector pair.
- Adds one clock of latency and a valid flag so that downstream pipeline stages can align data.

Parameters:
- WIDTH, 9, data width in bits. Must equal the shared `width` constant. Only 9 is supported.
- INIT_FILE, "sbox9_table.hex", hex file with 2**WIDTH entries, one per line. Entry k is S(k).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  substitution input word.
- a_valid  input  1  qualifies `a` in the current cycle.
- z  output  WIDTH  registered substitution result S(a).
- z_valid  output  1  high for one cycle per accepted input, aligned with `z`.

Behaviour:
- Reset:
  - While rst_n=0: z=0 and z_valid=0, asynchronously and independent of clk.
  - Deassertion is sampled at the next rising edge.
- Latency and hold:
  - Latency is exactly 1 cycle. If a_valid=1 at rising edge n, then z=S(a) and z_valid=1 after edge n.
  - If a_valid=0 at an edge, z_valid=0 and z holds its previous value. z is not cleared.
  - There is no backpressure. One word can be accepted every cycle, and back-to-back inputs produce back-to-back outputs.
- Table:
  - The table is a read-only array of 2**WIDTH x WIDTH, initialised from INIT_FILE at elaboration.
  - Index = unsigned `a`. Every index 0..511 is valid; there is no out-of-range case.
  - The table contents are a permutation of 0..511 (bijective). The first entries are:
    - S(0)=0x0A7, S(1)=0x0EF, S(2)=0x0A1, S(3)=0x17B, S(4)=0x187, S(5)=0x14E.
- The lookup is combinational from `a`. Only the output stage is registered; there is no input register.
- X/Z on `a` while a_valid=0 must not corrupt `z`.
- Reset during a stream:
  - In-flight data is discarded, z_valid drops immediately and z becomes 0.
  - The first valid input after release behaves as above.
- A synthesisable alternative to file init is a decoder-based realisation:
  - A 4-to-16 decoder on a[8:5] and a 5-to-32 decoder on a[4:0] drive per-output-bit minterm OR planes.
  - It must be bit-exact with the table.

Decomposition:
- Shared package/header:
  - the `width` constant (9);
  - the default table file name;
  - a function `sbox9_ref(input [8:0])` for testbench golden checks.
- One sub-module, sbox_9_lut. It is purely combinational (`a` in, S(a) out) and holds the table or the decoder/OR-plane logic.
- The top level sbox_9 adds only the output register and the valid pipeline.

Test Plan:
- Reset: hold rst_n=0 with a_valid=1 and a=0x003 for 3 cycles -> z=0x000 and z_valid=0 throughout. Also assert rst_n=0 asynchronously between edges -> z and z_valid clear before the next edge.
- Single lookups: a=0x000, then a=0x001, then a=0x003, each with a_valid=1 and one idle cycle between -> z=0x0A7, 0x0EF and 0x17B respectively, each one cycle later with a single-cycle z_valid pulse.
- Back-to-back stream: feed a=0..511 with a_valid=1 every cycle -> 512 consecutive z_valid cycles. z equals the golden table in order, and the collected outputs contain every value 0..511 exactly once (bijectivity).
- Hold: a_valid=1 with a=0x004, then a_valid=0 while `a` toggles randomly for 5 cycles -> z stays 0x187 and z_valid=0 after the first output cycle.
- Mid-stream reset: stream a=0x010..0x01F and pulse rst_n low during the stream -> outputs immediately 0/0. After release, a=0x005 -> z=0x14E one cycle later.
- Boundary: a=0x1FF and a=0x100 -> outputs match golden entries 511 and 256. There is no index wrap or truncation.
